fir_coefficient_controller: RTL and testbench

FIR_COEFFICIENT_CONTROLLER -- requirements
Module: fir_coefficient_controller

---
 rtl/fir_coefficient_controller.sv | 150 +++++++++++++++
 tb/tb_fir_coefficient_controller.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_coefficient_controller.sv
// Coefficient bank store and reload sequencer for a streaming FIR filter.
// Optional drain watchdog: define FIR_COEF_CTRL_DRAIN_WATCHDOG_EN.
//
// Handshakes: a beat transfers on any clock edge where valid and ready are
// both high; valid never waits for ready, and data is held while valid is
// high and ready is low.
module fir_coefficient_controller #(
   parameter int NUMBER_TAPS       = 16,
   parameter int COEFFICIENT_WIDTH = 16,
   parameter int NUMBER_BANKS      = 2,
   parameter int DRAIN_TIMEOUT     = 64
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic                                cfg_wr_en,
   input  logic [$clog2(NUMBER_BANKS)-1:0]     cfg_wr_bank,
   input  logic [$clog2(NUMBER_TAPS)-1:0]      cfg_wr_addr,
   input  logic [COEFFICIENT_WIDTH-1:0]        cfg_wr_data,
   output logic                                cfg_wr_error,
   input  logic                                load_req,
   input  logic [$clog2(NUMBER_BANKS)-1:0]     load_bank,
   output logic                                load_busy,
   output logic [$clog2(NUMBER_BANKS)-1:0]     active_bank,
   input  logic                                up_tvalid,
   input  logic                                up_tlast,
   output logic                                up_tready,
   output logic                                filter_tvalid,
   input  logic                                filter_tready,
   input  logic                                filter_samples_remaining,
   output logic                                coefficients_out_aresetn,
   output logic [COEFFICIENT_WIDTH-1:0]        coefficients_out_tdata,
   output logic                                coefficients_out_tvalid,
   output logic                                coefficients_out_tlast,
   input  logic                                coefficients_out_tready,
   output logic                                drain_timeout
);

   localparam int BW = $clog2(NUMBER_BANKS);
   localparam int TW = $clog2(NUMBER_TAPS);
   localparam logic [TW-1:0] LAST_TAP = TW'(NUMBER_TAPS - 1);

   typedef enum logic [2:0] {
      ST_IDLE, ST_WAIT_DRAIN, ST_CLEAR, ST_LOAD, ST_RUN
   } state_t;

   state_t                 state, state_next;
   logic                   pending;
   logic [BW-1:0]          pending_bank;
   logic [BW-1:0]          load_sel;
   logic [TW-1:0]          tap_idx;
   logic                   frame_active;
   logic                   start_load, last_beat, wr_conflict, up_beat, gate_open, wd_expire;

   logic [COEFFICIENT_WIDTH-1:0] coef_mem [NUMBER_BANKS][NUMBER_TAPS];

   assign start_load  = (state == ST_IDLE || state == ST_RUN) && (pending || load_req);
   assign last_beat   = (state == ST_LOAD) && coefficients_out_tready && (tap_idx == LAST_TAP);
   assign wr_conflict = cfg_wr_en && (state == ST_CLEAR || state == ST_LOAD) && (cfg_wr_bank == load_sel);
   assign up_beat     = up_tvalid && up_tready;

   always_ff @(posedge clock) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE, ST_RUN: if (pending || load_req) state_next = ST_WAIT_DRAIN;
         ST_WAIT_DRAIN:   if ((!frame_active && !filter_samples_remaining) || wd_expire)
                             state_next = ST_CLEAR;
         ST_CLEAR:        state_next = ST_LOAD;
         ST_LOAD:         if (last_beat) state_next = ST_RUN;
         default:         state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      gate_open                = 1'b0;
      load_busy                = 1'b0;
      coefficients_out_aresetn = 1'b0;
      coefficients_out_tvalid  = 1'b0;
      coefficients_out_tlast   = 1'b0;
      coefficients_out_tdata   = '0;
      if (!reset) begin
         gate_open                = (state == ST_RUN) || (state == ST_WAIT_DRAIN && frame_active);
         load_busy                = !(state == ST_IDLE || state == ST_RUN);
         coefficients_out_aresetn = (state != ST_CLEAR);
         coefficients_out_tvalid  = (state == ST_LOAD);
         coefficients_out_tlast   = (state == ST_LOAD) && (tap_idx == LAST_TAP);
         if (state == ST_LOAD) coefficients_out_tdata = coef_mem[load_sel][tap_idx];
      end
      up_tready     = gate_open && filter_tready;
      filter_tvalid = gate_open && up_tvalid;
   end

   // A request arriving while a load is being started is consumed directly;
   // any other request overwrites the single pending slot.
   always_ff @(posedge clock) begin
      if (reset) begin
         pending      <= 1'b0;
         pending_bank <= '0;
         load_sel     <= '0;
         active_bank  <= '0;
         frame_active <= 1'b0;
         tap_idx      <= '0;
         cfg_wr_error <= 1'b0;
      end else begin
         cfg_wr_error <= wr_conflict;
         if (up_beat) frame_active <= !up_tlast;
         if (start_load) begin
            pending  <= 1'b0;
            load_sel <= load_req ? load_bank : pending_bank;
         end else if (load_req) begin
            pending      <= 1'b1;
            pending_bank <= load_bank;
         end
         if (state == ST_LOAD && coefficients_out_tready)
            tap_idx <= (tap_idx == LAST_TAP) ? '0 : tap_idx + 1'b1;
         if (last_beat) active_bank <= load_sel;
      end
   end

   // Storage is plain memory: no reset, writes to the bank being loaded are dropped.
   always_ff @(posedge clock) begin
      if (cfg_wr_en && !wr_conflict) coef_mem[cfg_wr_bank][cfg_wr_addr] <= cfg_wr_data;
   end

`ifdef FIR_COEF_CTRL_DRAIN_WATCHDOG_EN
   localparam int WW = $clog2(DRAIN_TIMEOUT + 1);
   logic [WW-1:0] drain_count;
   logic          drain_timeout_q;

   assign wd_expire = (state == ST_WAIT_DRAIN) && !frame_active && filter_samples_remaining
                      && (drain_count == WW'(DRAIN_TIMEOUT - 1));

   always_ff @(posedge clock) begin
      if (reset || state != ST_WAIT_DRAIN) drain_count <= '0;
      else if (!frame_active)              drain_count <= drain_count + 1'b1;
      drain_timeout_q <= reset ? 1'b0 : wd_expire;
   end

   assign drain_timeout = drain_timeout_q;
`else
   assign wd_expire     = 1'b0;
   // Watchdog absent: the limit parameter folds into a constant-zero output.
   assign drain_timeout = 1'b0 & (DRAIN_TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_fir_coefficient_controller.sv
// Bench for fir_coefficient_controller: coefficient beats are scored against
// a queue filled from a bank model whenever a load is requested.
module tb_fir_coefficient_controller;
   localparam int N  = 16;
   localparam int W  = 16;
   localparam int NB = 2;
   localparam int BW = $clog2(NB);
   localparam int TW = $clog2(N);

   logic          clock = 1'b0;
   logic          reset;
   logic          cfg_wr_en;
   logic [BW-1:0] cfg_wr_bank;
   logic [TW-1:0] cfg_wr_addr;
   logic [W-1:0]  cfg_wr_data;
   logic          cfg_wr_error;
   logic          load_req;
   logic [BW-1:0] load_bank;
   logic          load_busy;
   logic [BW-1:0] active_bank;
   logic          up_tvalid, up_tlast, up_tready;
   logic          filter_tvalid, filter_tready, filter_samples_remaining;
   logic          coefficients_out_aresetn;
   logic [W-1:0]  coefficients_out_tdata;
   logic          coefficients_out_tvalid, coefficients_out_tlast, coefficients_out_tready;
   logic          drain_timeout;

   fir_coefficient_controller #(
      .NUMBER_TAPS(N), .COEFFICIENT_WIDTH(W), .NUMBER_BANKS(NB), .DRAIN_TIMEOUT(64)
   ) dut (
      .clock(clock), .reset(reset),
      .cfg_wr_en(cfg_wr_en), .cfg_wr_bank(cfg_wr_bank), .cfg_wr_addr(cfg_wr_addr),
      .cfg_wr_data(cfg_wr_data), .cfg_wr_error(cfg_wr_error),
      .load_req(load_req), .load_bank(load_bank), .load_busy(load_busy),
      .active_bank(active_bank),
      .up_tvalid(up_tvalid), .up_tlast(up_tlast), .up_tready(up_tready),
      .filter_tvalid(filter_tvalid), .filter_tready(filter_tready),
      .filter_samples_remaining(filter_samples_remaining),
      .coefficients_out_aresetn(coefficients_out_aresetn),
      .coefficients_out_tdata(coefficients_out_tdata),
      .coefficients_out_tvalid(coefficients_out_tvalid),
      .coefficients_out_tlast(coefficients_out_tlast),
      .coefficients_out_tready(coefficients_out_tready),
      .drain_timeout(drain_timeout)
   );

   // clock / reset
   always #5 clock = ~clock;

   logic [W-1:0] bank_model [NB][N];
   logic [W-1:0] exp_q[$];
   int           tests_run = 0;
   int           tests_failed = 0;
   int           beat_idx = 0;
   logic         prev_stall = 1'b0;
   logic [W-1:0] prev_data = '0;
   logic [W-1:0] exp_word;
   logic         rdy_toggle = 1'b0;
   int           clear_at, first_beat_at, tlast_at, timeout_at, n_clear, wait_cycles;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      tests_run++;
      if (got !== want) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
      end
   endtask

   // driver tasks
   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic push_bank(input int b);
      for (int i = 0; i < N; i++) exp_q.push_back(bank_model[b][i]);
   endtask

   task automatic write_coef(input int b, input int a, input logic [W-1:0] d, input logic expect_err);
      next_cycle();
      cfg_wr_en   = 1'b1;
      cfg_wr_bank = BW'(b);
      cfg_wr_addr = TW'(a);
      cfg_wr_data = d;
      next_cycle();
      cfg_wr_en = 1'b0;
      @(negedge clock);
      check("cfg_wr_error", cfg_wr_error, expect_err);
      if (!expect_err) bank_model[b][a] = d;
   endtask

   task automatic request(input int b);
      next_cycle();
      load_req  = 1'b1;
      load_bank = BW'(b);
      next_cycle();
      load_req = 1'b0;
   endtask

   // Counts cycles from the one after the request (cycle 1) until load_busy falls.
   task automatic wait_not_busy(input int max_cycles);
      clear_at = -1; first_beat_at = -1; tlast_at = -1; timeout_at = -1;
      n_clear = 0; wait_cycles = 1;
      forever begin
         @(negedge clock);
         if (!coefficients_out_aresetn) begin
            n_clear++;
            if (clear_at < 0) clear_at = wait_cycles;
         end
         if (coefficients_out_tvalid && first_beat_at < 0) first_beat_at = wait_cycles;
         if (coefficients_out_tlast) tlast_at = wait_cycles;
         if (drain_timeout && timeout_at < 0) timeout_at = wait_cycles;
         if (!load_busy) break;
         if (wait_cycles >= max_cycles) begin
            check("busy_timeout", load_busy, 1'b0);
            break;
         end
         next_cycle();
         wait_cycles++;
         if (rdy_toggle) coefficients_out_tready = ~coefficients_out_tready;
      end
   endtask

   // scoreboard: every accepted coefficient beat pops one expected word
   always @(negedge clock) begin
      if (reset) begin
         prev_stall = 1'b0;
      end else if (coefficients_out_tvalid) begin
         if (prev_stall) check("tdata_hold", coefficients_out_tdata, prev_data);
         check("tlast", coefficients_out_tlast, beat_idx == N - 1);
         if (coefficients_out_tready) begin
            check("beat_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
               exp_word = exp_q.pop_front();
               check("tdata", coefficients_out_tdata, exp_word);
            end
            beat_idx   = (beat_idx == N - 1) ? 0 : beat_idx + 1;
            prev_stall = 1'b0;
         end else begin
            prev_stall = 1'b1;
            prev_data  = coefficients_out_tdata;
         end
      end else begin
         check("idle_out", {coefficients_out_tlast, coefficients_out_tdata}, '0);
         prev_stall = 1'b0;
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      reset = 1'b1; cfg_wr_en = 1'b0; cfg_wr_bank = '0; cfg_wr_addr = '0; cfg_wr_data = '0;
      load_req = 1'b1; load_bank = 1'b1; up_tvalid = 1'b1; up_tlast = 1'b0;
      filter_tready = 1'b1; filter_samples_remaining = 1'b0; coefficients_out_tready = 1'b1;

      repeat (3) next_cycle();
      @(negedge clock);
      check("rst_busy", load_busy, 1'b0);
      check("rst_active", active_bank, '0);
      check("rst_up_tready", up_tready, 1'b0);
      check("rst_filter_tvalid", filter_tvalid, 1'b0);
      check("rst_aresetn", coefficients_out_aresetn, 1'b0);
      check("rst_tvalid", coefficients_out_tvalid, 1'b0);
      check("rst_tlast", coefficients_out_tlast, 1'b0);
      check("rst_wr_error", cfg_wr_error, 1'b0);
      check("rst_drain_timeout", drain_timeout, 1'b0);

      next_cycle();
      reset = 1'b0; load_req = 1'b0;
      @(negedge clock);
      check("idle_aresetn", coefficients_out_aresetn, 1'b1);
      check("idle_busy", load_busy, 1'b0);
      check("idle_up_tready", up_tready, 1'b0);
      check("idle_filter_tvalid", filter_tvalid, 1'b0);
      next_cycle();
      up_tvalid = 1'b0;
      @(negedge clock);
      check("idle_no_pending", load_busy, 1'b0);

      for (int a = 0; a < N; a++) write_coef(1, a, W'(a + 1), 1'b0);
      for (int a = 0; a < N; a++) write_coef(0, a, W'($urandom_range(0, 65535)), 1'b0);

      // basic load of bank 1, full-rate
      push_bank(1);
      request(1);
      wait_not_busy(100);
      check("basic_clear_at", clear_at, 2);
      check("basic_clear_len", n_clear, 1);
      check("basic_first_beat", first_beat_at, 3);
      check("basic_tlast_at", tlast_at, 18);
      check("basic_run_at", wait_cycles, 19);
      check("basic_active", active_bank, 1);
      check("basic_drained", exp_q.size(), 0);
      check("basic_no_timeout", timeout_at, -1);

      // gate open in RUN
      next_cycle();
      up_tvalid = 1'b1; filter_tready = 1'b0;
      @(negedge clock);
      check("run_up_tready_lo", up_tready, 1'b0);
      check("run_filter_tvalid", filter_tvalid, 1'b1);
      next_cycle();
      up_tvalid = 1'b0; filter_tready = 1'b1;
      @(negedge clock);
      check("run_up_tready_hi", up_tready, 1'b1);
      check("run_filter_tvalid_lo", filter_tvalid, 1'b0);

      // write to the bank being loaded is rejected, other bank is accepted
      push_bank(1);
      request(1);
      repeat (3) next_cycle();
      write_coef(1, 5, 16'hDEAD, 1'b1);
      write_coef(0, 2, 16'h1234, 1'b0);
      next_cycle();
      wait_not_busy(100);
      check("conflict_drained", exp_q.size(), 0);
      check("conflict_active", active_bank, 1);

      // backpressure: tready toggles every cycle
      push_bank(0);
      rdy_toggle = 1'b1;
      request(0);
      wait_not_busy(150);
      rdy_toggle = 1'b0;
      coefficients_out_tready = 1'b1;
      check("bp_drained", exp_q.size(), 0);
      check("bp_beat_idx", beat_idx, 0);
      check("bp_active", active_bank, 0);

      // mid-frame request: the frame finishes before the gate closes
      push_bank(1);
      next_cycle();
      filter_samples_remaining = 1'b1;
      up_tvalid = 1'b1;
      for (int b = 1; b <= 10; b++) begin
         up_tlast  = (b == 10);
         load_req  = (b == 4);
         load_bank = 1'b1;
         @(negedge clock);
         if (b >= 4) begin
            check("frame_up_tready", up_tready, 1'b1);
            check("frame_filter_tvalid", filter_tvalid, 1'b1);
         end
         next_cycle();
      end
      load_req = 1'b0; up_tlast = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         check("drain_gate_closed", {up_tready, filter_tvalid}, '0);
         check("drain_hold", {load_busy, coefficients_out_aresetn}, 2'b11);
         next_cycle();
      end
      filter_samples_remaining = 1'b0;
      @(negedge clock);
      check("drain_last_wait", coefficients_out_aresetn, 1'b1);
      next_cycle();
      @(negedge clock);
      check("drain_clear", coefficients_out_aresetn, 1'b0);
      next_cycle();
      up_tvalid = 1'b0;
      wait_not_busy(100);
      check("frame_active_bank", active_bank, 1);
      check("frame_drained", exp_q.size(), 0);

      // two requests during LOAD: one extra load, of the last bank asked for
      push_bank(0);
      push_bank(1);
      request(0);
      repeat (3) next_cycle();
      load_req = 1'b1; load_bank = 1'b0;
      next_cycle();
      load_bank = 1'b1;
      next_cycle();
      load_req = 1'b0;
      wait_not_busy(100);
      check("queue_first_active", active_bank, 0);
      next_cycle();
      @(negedge clock);
      check("queue_reload", load_busy, 1'b1);
      next_cycle();
      wait_not_busy(100);
      check("queue_active", active_bank, 1);
      check("queue_drained", exp_q.size(), 0);
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         @(negedge clock);
         check("queue_no_third", load_busy, 1'b0);
      end

      // reset in the middle of a load
      push_bank(0);
      request(0);
      repeat (5) next_cycle();
      reset = 1'b1;
      @(negedge clock);
      check("abort_tvalid_now", coefficients_out_tvalid, 1'b0);
      next_cycle();
      @(negedge clock);
      check("abort_tvalid", coefficients_out_tvalid, 1'b0);
      check("abort_busy", load_busy, 1'b0);
      check("abort_active", active_bank, 0);
      exp_q.delete();
      beat_idx = 0;
      next_cycle();
      reset = 1'b0;
      push_bank(1);
      request(1);
      wait_not_busy(100);
      check("reload_run_at", wait_cycles, 19);
      check("reload_active", active_bank, 1);
      check("reload_drained", exp_q.size(), 0);

`ifdef FIR_COEF_CTRL_DRAIN_WATCHDOG_EN
      push_bank(0);
      filter_samples_remaining = 1'b1;
      request(0);
      wait_not_busy(200);
      filter_samples_remaining = 1'b0;
      check("wd_timeout_at", timeout_at, 65);
      check("wd_clear_at", clear_at, 65);
      check("wd_run_at", wait_cycles, 82);
      check("wd_drained", exp_q.size(), 0);
`else
      push_bank(0);
      filter_samples_remaining = 1'b1;
      request(0);
      for (int i = 0; i < 80; i++) begin
         @(negedge clock);
         check("no_wd_wait", {drain_timeout, coefficients_out_aresetn, load_busy}, 3'b011);
         next_cycle();
      end
      filter_samples_remaining = 1'b0;
      wait_not_busy(50);
      check("no_wd_clear_at", clear_at, 2);
      check("no_wd_drained", exp_q.size(), 0);
`endif

      repeat (2) next_cycle();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
